// File: rtl/xheep_boot_seq_pkg.sv
// Shared types for the X-HEEP boot sequencer.
// State encoding is visible on state_o and the PS GPIO status word.
package xheep_boot_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_HOLD_RST  = 3'd2,
    S_REL_JTAG  = 3'd3,
    S_RUN       = 3'd4,
    S_DONE      = 3'd5
  } boot_state_e;

  // Bit positions of the status word presented to the PS GPIO block
  localparam int unsigned STAT_BUSY      = 0;
  localparam int unsigned STAT_DONE      = 1;
  localparam int unsigned STAT_PASS      = 2;
  localparam int unsigned STAT_TIMEOUT   = 3;
  localparam int unsigned STAT_LOCK_LOST = 4;
  localparam int unsigned STAT_RST_N     = 5;
  localparam int unsigned STAT_TRST_N    = 6;
  localparam int unsigned STAT_W         = 7;

  // {busy, done} as seen once the FSM sits in state s
  function automatic logic [1:0] state_flags(
    input boot_state_e s
  );
    logic busy;
    logic done;
    busy = (s != S_IDLE) && (s != S_DONE);
    done = (s == S_DONE);
    return {busy, done};
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
// Both flops clear to 0 so an unlocked clock is assumed after reset.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      q_o    <= 1'b0;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end

endmodule

// File: rtl/xheep_boot_sequencer.sv
// Sequences X-HEEP reset, boot mode and JTAG TAP release on the FPGA,
// then watches the exit handshake with an optional cycle timeout.
module xheep_boot_sequencer
  import xheep_boot_seq_pkg::*;
#(
  parameter int unsigned RST_HOLD_CYCLES   = 16,
  parameter int unsigned JTAG_DELAY_CYCLES = 4,
  parameter int unsigned TIMEOUT_W         = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clk_locked_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic                 boot_select_cfg_i,
  input  logic                 exec_flash_cfg_i,
  input  logic [TIMEOUT_W-1:0] timeout_cycles_i,
  input  logic                 exit_valid_i,
  input  logic [31:0]          exit_value_i,
  output logic                 xheep_rst_no,
  output logic                 jtag_trst_no,
  output logic                 boot_select_o,
  output logic                 execute_from_flash_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic                 timeout_o,
  output logic                 lock_lost_o,
  output logic [TIMEOUT_W-1:0] run_cycles_o,
  output logic [2:0]           state_o
);

  localparam int unsigned CNT_MAX =
    (RST_HOLD_CYCLES > JTAG_DELAY_CYCLES) ?
    RST_HOLD_CYCLES : JTAG_DELAY_CYCLES;
  localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] HOLD_LD =
    CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] JTAG_LD =
    CNT_W'(JTAG_DELAY_CYCLES - 1);

  boot_state_e          state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [TIMEOUT_W-1:0] timeout_q;
  logic                 lock_s;
  logic                 lock_drop;
  logic                 tmo_hit;
  logic                 cnt_zero;
  logic [TIMEOUT_W-1:0] run_inc;

  sync_2ff u_lock_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (clk_locked_i),
    .q_o   (lock_s)
  );

  assign state_o  = state_q;
  assign cnt_zero = (cnt_q == '0);

  assign lock_drop = !lock_s &&
    (state_q inside {S_HOLD_RST, S_REL_JTAG, S_RUN, S_DONE});

  // Fires in the last allowed RUN cycle, so DONE holds the full count
  assign tmo_hit = (timeout_q != '0) &&
    (run_cycles_o == timeout_q - TIMEOUT_W'(1));

  assign run_inc = (&run_cycles_o) ? run_cycles_o :
    run_cycles_o + TIMEOUT_W'(1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q              <= S_IDLE;
      cnt_q                <= '0;
      timeout_q            <= '0;
      xheep_rst_no         <= 1'b0;
      jtag_trst_no         <= 1'b0;
      boot_select_o        <= 1'b0;
      execute_from_flash_o <= 1'b0;
      busy_o               <= 1'b0;
      done_o               <= 1'b0;
      pass_o               <= 1'b0;
      timeout_o            <= 1'b0;
      lock_lost_o          <= 1'b0;
      run_cycles_o         <= '0;
    end else if (abort_i) begin
      state_q          <= S_IDLE;
      xheep_rst_no     <= 1'b0;
      jtag_trst_no     <= 1'b0;
      {busy_o, done_o} <= state_flags(S_IDLE);
    end else if (lock_drop) begin
      state_q          <= S_WAIT_LOCK;
      xheep_rst_no     <= 1'b0;
      jtag_trst_no     <= 1'b0;
      lock_lost_o      <= 1'b1;
      cnt_q            <= '0;
      run_cycles_o     <= '0;
      {busy_o, done_o} <= state_flags(S_WAIT_LOCK);
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state_q              <= S_WAIT_LOCK;
            xheep_rst_no         <= 1'b0;
            jtag_trst_no         <= 1'b0;
            boot_select_o        <= boot_select_cfg_i;
            execute_from_flash_o <= exec_flash_cfg_i;
            timeout_q            <= timeout_cycles_i;
            pass_o               <= 1'b0;
            timeout_o            <= 1'b0;
            lock_lost_o          <= 1'b0;
            run_cycles_o         <= '0;
            cnt_q                <= '0;
            {busy_o, done_o}     <= state_flags(S_WAIT_LOCK);
          end
        end
        S_WAIT_LOCK: begin
          if (lock_s) begin
            state_q          <= S_HOLD_RST;
            cnt_q            <= HOLD_LD;
            {busy_o, done_o} <= state_flags(S_HOLD_RST);
          end
        end
        S_HOLD_RST: begin
          if (cnt_zero) begin
            state_q          <= S_REL_JTAG;
            xheep_rst_no     <= 1'b1;
            cnt_q            <= JTAG_LD;
            {busy_o, done_o} <= state_flags(S_REL_JTAG);
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_REL_JTAG: begin
          if (cnt_zero) begin
            state_q          <= S_RUN;
            jtag_trst_no     <= 1'b1;
            {busy_o, done_o} <= state_flags(S_RUN);
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_RUN: begin
          run_cycles_o <= run_inc;
          if (exit_valid_i) begin
            state_q          <= S_DONE;
            pass_o           <= (exit_value_i == '0);
            timeout_o        <= 1'b0;
            {busy_o, done_o} <= state_flags(S_DONE);
          end else if (tmo_hit) begin
            state_q          <= S_DONE;
            pass_o           <= 1'b0;
            timeout_o        <= 1'b1;
            {busy_o, done_o} <= state_flags(S_DONE);
          end
        end
        default: begin
          state_q          <= S_IDLE;
          xheep_rst_no     <= 1'b0;
          jtag_trst_no     <= 1'b0;
          {busy_o, done_o} <= state_flags(S_IDLE);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xheep_boot_sequencer.sv
// Scoreboard bench for the X-HEEP boot sequencer: randomized runs
// are scored against an outcome model, a monitor checks each event.
module tb_xheep_boot_sequencer;

  localparam int HOLD = 16;
  localparam int JDLY = 4;
  localparam int TW   = 32;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          clk_locked = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          boot = 1'b0;
  logic          flash = 1'b0;
  logic [TW-1:0] tmo = '0;
  logic          exit_valid = 1'b0;
  logic [31:0]   exit_value = '0;

  logic          xheep_rst_no;
  logic          jtag_trst_no;
  logic          boot_select_o;
  logic          execute_from_flash_o;
  logic          busy_o;
  logic          done_o;
  logic          pass_o;
  logic          timeout_o;
  logic          lock_lost_o;
  logic [TW-1:0] run_cycles_o;
  logic [2:0]    state_o;

  xheep_boot_sequencer #(
    .RST_HOLD_CYCLES   (HOLD),
    .JTAG_DELAY_CYCLES (JDLY),
    .TIMEOUT_W         (TW)
  ) dut (
    .clk_i                (clk),
    .rst_i                (rst_i),
    .clk_locked_i         (clk_locked),
    .start_i              (start),
    .abort_i              (abort),
    .boot_select_cfg_i    (boot),
    .exec_flash_cfg_i     (flash),
    .timeout_cycles_i     (tmo),
    .exit_valid_i         (exit_valid),
    .exit_value_i         (exit_value),
    .xheep_rst_no         (xheep_rst_no),
    .jtag_trst_no         (jtag_trst_no),
    .boot_select_o        (boot_select_o),
    .execute_from_flash_o (execute_from_flash_o),
    .busy_o               (busy_o),
    .done_o               (done_o),
    .pass_o               (pass_o),
    .timeout_o            (timeout_o),
    .lock_lost_o          (lock_lost_o),
    .run_cycles_o         (run_cycles_o),
    .state_o              (state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          pass;
    bit          tmo;
    bit          lost;
    bit          chk_cyc;
    int unsigned cyc;
    bit          boot;
    bit          flash;
  } done_exp_t;

  typedef struct {
    int hold;
    int jd;
  } rel_exp_t;

  done_exp_t done_q[$];
  rel_exp_t  rel_q[$];

  int n_chk  = 0;
  int n_pass = 0;
  bit last_pass = 1'b0;

  task automatic chk(input string name,
                     input longint unsigned act,
                     input longint unsigned exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Outcome of one run from the rules: the first of exit cycle e and
  // timeout t ends it, exit winning a tie; e=0 means no exit, t=0 no timeout
  function automatic done_exp_t model(
    input bit b, input bit f,
    input int unsigned t, input int unsigned e,
    input logic [31:0] v, input bit lost, input bit chk_cyc
  );
    done_exp_t m;
    m.boot = b;
    m.flash = f;
    m.lost = lost;
    m.chk_cyc = chk_cyc;
    if (e != 0 && (t == 0 || e <= t)) begin
      m.pass = (v == 0);
      m.tmo  = 1'b0;
      m.cyc  = e;
    end else begin
      m.pass = 1'b0;
      m.tmo  = 1'b1;
      m.cyc  = t;
    end
    return m;
  endfunction

  // Monitor: scores reset-release timing and every DONE entry
  int cyc = 0;
  int hcnt = 0;
  int hold_seen = 0;
  int rel_at = 0;
  logic p_x = 1'b0;
  logic p_j = 1'b0;
  logic p_d = 1'b0;
  rel_exp_t  mr;
  done_exp_t md;

  always @(negedge clk) begin
    cyc++;
    if (!rst_i) begin
      if (xheep_rst_no && !p_x) begin
        hold_seen = hcnt;
        rel_at = cyc;
      end
      if (jtag_trst_no && !p_j) begin
        if (rel_q.size() == 0) begin
          chk("unexpected_release", 1, 0);
        end else begin
          mr = rel_q.pop_front();
          chk("hold_len", hold_seen, mr.hold);
          chk("jtag_delay", cyc - rel_at, mr.jd);
        end
      end
      if (done_o && !p_d) begin
        if (done_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          md = done_q.pop_front();
          chk("done_pass", pass_o, md.pass);
          chk("done_timeout", timeout_o, md.tmo);
          chk("done_lock_lost", lock_lost_o, md.lost);
          chk("done_boot_sel", boot_select_o, md.boot);
          chk("done_exec_flash", execute_from_flash_o, md.flash);
          chk("done_resets_rel", {xheep_rst_no, jtag_trst_no}, 3);
          if (md.chk_cyc) chk("done_run_cycles", run_cycles_o, md.cyc);
        end
      end
    end
    hcnt = (state_o == 3'd2) ? hcnt + 1 : 0;
    p_x = xheep_rst_no;
    p_j = jtag_trst_no;
    p_d = done_o;
  end

  task automatic wait_jtag();
    for (int i = 0; i < 200 && !jtag_trst_no; i++) @(negedge clk);
    chk("wait_jtag_release", jtag_trst_no, 1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3000 && !done_o; i++) @(negedge clk);
    chk("wait_done", done_o, 1);
  endtask

  task automatic issue_start(input bit b, input bit f,
                             input int unsigned t);
    @(negedge clk);
    boot = b;
    flash = f;
    tmo = t;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    boot = ~b;
    flash = ~f;
    tmo = $urandom;
  endtask

  task automatic do_run(input bit b, input bit f,
                        input int unsigned t, input int unsigned e,
                        input logic [31:0] v);
    done_exp_t m;
    m = model(b, f, t, e, v, 1'b0, 1'b1);
    last_pass = m.pass;
    done_q.push_back(m);
    rel_q.push_back('{HOLD, JDLY});
    issue_start(b, f, t);
    wait_jtag();
    if (e >= 3) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (e - 2) @(negedge clk);
    end else if (e != 0) begin
      repeat (e - 1) @(negedge clk);
    end
    if (e != 0) begin
      exit_valid = 1'b1;
      exit_value = v;
      @(negedge clk);
      exit_valid = 1'b0;
      exit_value = $urandom;
    end
    wait_done();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t;
    int unsigned e;
    logic [31:0] v;
    int n;

    repeat (3) @(negedge clk);
    chk("rst_state", state_o, 0);
    chk("rst_resets", {xheep_rst_no, jtag_trst_no}, 0);
    chk("rst_flags", {busy_o, done_o, pass_o, timeout_o, lock_lost_o}, 0);
    chk("rst_cfg", {boot_select_o, execute_from_flash_o}, 0);
    chk("rst_run_cycles", run_cycles_o, 0);
    rst_i = 1'b0;
    clk_locked = 1'b1;
    repeat (3) @(negedge clk);

    do_run(1'b1, 1'b0, 1000, 200, 32'h0);
    do_run(1'b1, 1'b0, 1000, 200, 32'h5);
    do_run(1'b0, 1'b1, 50, 0, 32'h0);
    do_run(1'b0, 1'b0, 50, 50, 32'h0);

    for (int k = 0; k < 20; k++) begin
      t = $urandom_range(120);
      e = $urandom_range(150, 1);
      if (t != 0 && $urandom_range(4) == 0) e = 0;
      v = ($urandom_range(1) == 0) ? 32'h0 : $urandom;
      do_run($urandom_range(1), $urandom_range(1), t, e, v);
    end

    // abort beats a simultaneous start in DONE; status holds
    @(negedge clk);
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    chk("abort_state", state_o, 0);
    chk("abort_resets", {xheep_rst_no, jtag_trst_no}, 0);
    chk("abort_busy_done", {busy_o, done_o}, 0);
    chk("abort_pass_hold", pass_o, last_pass);

    // lock gating and lock loss during RUN
    clk_locked = 1'b0;
    repeat (4) @(negedge clk);
    done_q.push_back(model(1'b1, 1'b1, 0, 10, 32'h0, 1'b1, 1'b0));
    rel_q.push_back('{HOLD, JDLY});
    rel_q.push_back('{HOLD, JDLY});
    issue_start(1'b1, 1'b1, 0);
    repeat (30) @(negedge clk);
    chk("nolock_state", state_o, 1);
    chk("nolock_resets", {xheep_rst_no, jtag_trst_no}, 0);
    clk_locked = 1'b1;
    n = 0;
    while (state_o != 3'd2 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("lock_gate_min", n >= 2, 1);
    chk("lock_gate_max", n <= 3, 1);
    wait_jtag();
    repeat (20) @(negedge clk);
    clk_locked = 1'b0;
    repeat (5) @(negedge clk);
    chk("lockloss_resets", {xheep_rst_no, jtag_trst_no}, 0);
    chk("lockloss_sticky", lock_lost_o, 1);
    chk("lockloss_state", state_o, 1);
    clk_locked = 1'b1;
    wait_jtag();
    repeat (9) @(negedge clk);
    exit_valid = 1'b1;
    exit_value = 32'h0;
    @(negedge clk);
    exit_valid = 1'b0;
    wait_done();

    // asynchronous reset mid-RUN
    rel_q.push_back('{HOLD, JDLY});
    issue_start(1'b1, 1'b0, 0);
    wait_jtag();
    repeat (30) @(negedge clk);
    #2 rst_i = 1'b1;
    #1;
    chk("arst_state", state_o, 0);
    chk("arst_resets", {xheep_rst_no, jtag_trst_no}, 0);
    chk("arst_flags", {busy_o, done_o, pass_o, timeout_o, lock_lost_o}, 0);
    chk("arst_cfg", {boot_select_o, execute_from_flash_o}, 0);
    chk("arst_run_cycles", run_cycles_o, 0);
    @(negedge clk);
    rst_i = 1'b0;
    repeat (2) @(negedge clk);

    // timeout disabled: still running after 2^16 cycles
    rel_q.push_back('{HOLD, JDLY});
    issue_start(1'b0, 1'b1, 0);
    wait_jtag();
    repeat (65536) @(negedge clk);
    chk("notmo_state", state_o, 4);
    chk("notmo_timeout", timeout_o, 0);
    chk("notmo_run_cycles", run_cycles_o, 65536);
    chk("notmo_busy", busy_o, 1);
    chk("notmo_flash", execute_from_flash_o, 1);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("final_abort_state", state_o, 0);

    repeat (2) @(negedge clk);
    chk("done_q_drained", done_q.size(), 0);
    chk("rel_q_drained", rel_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/xheep_boot_sequencer.md
Name: xheep_boot_sequencer

Overview:
- FPGA-side controller that sequences X-HEEP bring-up on the board wrapper: reset, boot mode, JTAG TAP reset release, and test completion.
- Sits between the PS GPIO/buttons and the x_heep_system control pins (rst_ni, boot_select_i, execute_from_flash_i, jtag_trst_ni, exit_valid_o, exit_value_o).
- Gates reset on clock-wizard lock, holds reset for a fixed window, and staggers JTAG TAP release after core reset.
- Watches exit_valid with a programmable timeout and reports pass/fail, timeout, cycle count and lock loss.

Parameters:
- RST_HOLD_CYCLES, 16: cycles xheep_rst_no is held low after lock (>=1).
- JTAG_DELAY_CYCLES, 4: cycles between xheep_rst_no release and jtag_trst_no release (>=1).
- TIMEOUT_W, 32: width of the timeout value and the run cycle counter.

Ports:
- clk_i  in  1  clk_gen domain clock.
- rst_i  in  1  asynchronous, active-high reset.
- clk_locked_i  in  1  clock-wizard lock, asynchronous; double-flop synchronised internally.
- start_i  in  1  single-cycle start/restart request.
- abort_i  in  1  level; forces IDLE.
- boot_select_cfg_i  in  1  boot mode, latched on start.
- exec_flash_cfg_i  in  1  execute-from-flash, latched on start.
- timeout_cycles_i  in  TIMEOUT_W  run timeout, latched on start; 0 = disabled.
- exit_valid_i  in  1  from x_heep_system exit_valid_o.
- exit_value_i  in  32  from x_heep_system exit_value_o.
- xheep_rst_no  out  1  drives x_heep_system rst_ni.
- jtag_trst_no  out  1  drives jtag_trst_ni.
- boot_select_o  out  1  latched boot select.
- execute_from_flash_o  out  1  latched execute-from-flash.
- busy_o  out  1  state is not IDLE and not DONE.
- done_o  out  1  state is DONE.
- pass_o  out  1  exit seen and exit_value == 0.
- timeout_o  out  1  run timed out.
- lock_lost_o  out  1  sticky; lock dropped after reset release.
- run_cycles_o  out  TIMEOUT_W  cycles spent in RUN, frozen in DONE.
- state_o  out  3  encoding: IDLE=0, WAIT_LOCK=1, HOLD_RST=2, REL_JTAG=3, RUN=4, DONE=5.

Behaviour:
- Reset: all outputs 0, state IDLE. xheep_rst_no=0 and jtag_trst_no=0, so the SoC is held in reset.
- Every output is registered.
- IDLE: xheep_rst_no=0, jtag_trst_no=0.
  - start_i=1 latches the three cfg inputs, clears pass_o, timeout_o, lock_lost_o and run_cycles_o, and goes to WAIT_LOCK next cycle.
- WAIT_LOCK: both resets low. Leaves when synchronised lock = 1; load hold counter, go to HOLD_RST.
- HOLD_RST: xheep_rst_no=0 for exactly RST_HOLD_CYCLES cycles, then REL_JTAG.
- REL_JTAG:
  - xheep_rst_no=1 from the first cycle of this state.
  - jtag_trst_no stays 0 for JTAG_DELAY_CYCLES cycles, then goes to 1 on entry to RUN.
- RUN:
  - run_cycles_o increments every cycle and saturates at all-ones.
  - exit_valid_i=1 → DONE; pass_o = (exit_value_i == 0), registered the same cycle.
  - If timeout_cycles_i != 0 and run_cycles_o == timeout_cycles_i - 1 with no exit → DONE with timeout_o=1, pass_o=0.
  - Exit and timeout in the same cycle: exit wins, timeout_o=0.
- DONE: both resets remain released (SoC keeps running for debug); outputs hold.
  - start_i → WAIT_LOCK with the full re-sequence: resets reasserted, cfg relatched, status cleared.
- abort_i=1 in any state → IDLE next cycle, both resets low.
  - abort_i takes priority over start_i, exit and timeout.
  - Status outputs hold their values until the next start.
- Lock loss: synchronised lock=0 in HOLD_RST, REL_JTAG, RUN or DONE → WAIT_LOCK.
  - Both resets asserted the same cycle the state changes.
  - lock_lost_o=1 (sticky); counters reload.
- start_i in WAIT_LOCK, HOLD_RST, REL_JTAG or RUN is ignored.
- rst_i asserted mid-operation: immediate asynchronous return to the reset values above.

Decomposition:
- Package xheep_boot_seq_pkg: state enum (3-bit, values as listed above) and a status-bit index constant set for the PS GPIO mapping.
- One sub-module, sync_2ff (two-flop synchroniser with reset to 0), used for clk_locked_i.
- Hold and JTAG-delay counters are shared as one down-counter inside the top module.

Test Plan:
- Normal pass:
  - Stimulus: lock=1, start with boot=1, flash=0, timeout=1000; exit_valid asserted 200 cycles into RUN with value 0.
  - Response: xheep_rst_no low exactly 16 cycles; jtag_trst_no rises 4 cycles after it; done_o=1, pass_o=1, run_cycles_o=200, boot_select_o=1.
- Fail value:
  - Stimulus: as the pass case but exit_value=0x5.
  - Response: done_o=1, pass_o=0, timeout_o=0.
- Timeout:
  - Stimulus: timeout=50, no exit.
  - Response: DONE entered after exactly 50 RUN cycles, timeout_o=1, run_cycles_o=50.
  - Edge: exit_valid in cycle 50 → pass path, timeout_o=0.
- Lock gating and loss:
  - Stimulus: start with lock=0, raise lock 30 cycles later; later drop lock during RUN for 5 cycles.
  - Response: HOLD_RST is entered no earlier than 2 cycles after lock rises; on the drop both resets go low, lock_lost_o=1, and the block resequences after lock returns.
- Abort and reset priority:
  - Stimulus: abort_i together with start_i in DONE.
  - Response: IDLE, both resets low.
  - Stimulus: rst_i pulse mid-RUN.
  - Response: all outputs 0 asynchronously, state_o=0.
- Timeout disabled:
  - Stimulus: timeout=0, run 2^16 cycles with no exit.
  - Response: remains in RUN, timeout_o=0, run_cycles_o=65536.
